// File: rtl/demux32_4salidas_pkg.sv
// Shared constants, channel state encoding and popcount helper for the
// 1-to-4 registered demultiplexer.
package demux32_4salidas_pkg;

    localparam int unsigned NUM_CANALES = 4;
    localparam int unsigned WIDTH_DEF   = 32;

    localparam int unsigned CANAL_A = 0;
    localparam int unsigned CANAL_B = 1;
    localparam int unsigned CANAL_C = 2;
    localparam int unsigned CANAL_D = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } estadoCanal_t;

    // Number of set bits in a channel-valid vector (0..4).
    function automatic logic [2:0] contarUnos(input logic [NUM_CANALES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_CANALES; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/demux32_4salidas_canal_retencion.sv
// One-entry holding register for a single output channel; a load always wins
// over a drain so a same-cycle drain+refill keeps the channel full.
module canal_retencion
    import demux32_4salidas_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] dataIn,
    output logic             valid,
    output logic [WIDTH-1:0] dataOut
);

    estadoCanal_t     estado;
    estadoCanal_t     estadoNext;
    logic [WIDTH-1:0] dato;
    logic [WIDTH-1:0] datoNext;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado <= EMPTY;
            dato   <= '0;
        end else begin
            estado <= estadoNext;
            dato   <= datoNext;
        end
    end

    always_comb begin
        estadoNext = estado;
        datoNext   = dato;
        if (load) begin
            estadoNext = FULL;
            datoNext   = dataIn;
        end else if ((estado == FULL) && drain) begin
            estadoNext = EMPTY;
        end
    end

    assign valid   = (estado == FULL);
    assign dataOut = dato;

endmodule

// File: rtl/demux32_4salidas.sv
// Registered 1-to-4 demultiplexer: steers one word per cycle to the channel
// chosen by sel; each channel stalls independently.
module demux32_4salidas
    import demux32_4salidas_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             sel,
    input  logic [WIDTH-1:0]       entrada,
    input  logic                   entrada_valid,
    output logic                   entrada_ready,
    output logic [WIDTH-1:0]       salidaA,
    output logic [WIDTH-1:0]       salidaB,
    output logic [WIDTH-1:0]       salidaC,
    output logic [WIDTH-1:0]       salidaD,
    output logic [NUM_CANALES-1:0] salida_valid,
    input  logic [NUM_CANALES-1:0] salida_ready,
    output logic [2:0]             ocupados
);

    logic [NUM_CANALES-1:0] load;
    logic [NUM_CANALES-1:0] validNext;
    logic [WIDTH-1:0]       datos [NUM_CANALES];

    assign entrada_ready = ~salida_valid[sel] | salida_ready[sel];

    // Load decode is gated by entrada_valid first so an unknown sel while idle
    // cannot reach any channel.
    always_comb begin
        load = '0;
        if (entrada_valid && entrada_ready) begin
            load[sel] = 1'b1;
        end
    end

    assign validNext = load | (salida_valid & ~salida_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ocupados <= '0;
        end else begin
            ocupados <= contarUnos(validNext);
        end
    end

    for (genvar i = 0; i < NUM_CANALES; i++) begin : g_canal
        canal_retencion #(
            .WIDTH (WIDTH)
        ) u_canal (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[i]),
            .drain   (salida_ready[i]),
            .dataIn  (entrada),
            .valid   (salida_valid[i]),
            .dataOut (datos[i])
        );
    end

    assign salidaA = datos[CANAL_A];
    assign salidaB = datos[CANAL_B];
    assign salidaC = datos[CANAL_C];
    assign salidaD = datos[CANAL_D];

endmodule

// File: tb/tb_demux32_4salidas.sv
// Directed and random-traffic bench for demux32_4salidas.
module tb_demux32_4salidas;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    logic [31:0] entrada;
    logic        entrada_valid;
    logic        entrada_ready;
    logic [31:0] salidaA, salidaB, salidaC, salidaD;
    logic [3:0]  salida_valid;
    logic [3:0]  salida_ready;
    logic [2:0]  ocupados;

    int checks = 0;
    int errors = 0;

    demux32_4salidas #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sel           (sel),
        .entrada       (entrada),
        .entrada_valid (entrada_valid),
        .entrada_ready (entrada_ready),
        .salidaA       (salidaA),
        .salidaB       (salidaB),
        .salidaC       (salidaC),
        .salidaD       (salidaD),
        .salida_valid  (salida_valid),
        .salida_ready  (salida_ready),
        .ocupados      (ocupados)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] salidaDe(input int i);
        case (i)
            0: return salidaA;
            1: return salidaB;
            2: return salidaC;
            default: return salidaD;
        endcase
    endfunction

    function automatic logic [2:0] popcnt(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [31:0] cola [4][$];
    logic        hold;
    logic        expRdy;
    logic        acc;
    logic [3:0]  expV;
    logic [31:0] w;

    initial begin
        reset_n       = 1'b0;
        sel           = 2'd0;
        entrada       = '0;
        entrada_valid = 1'b0;
        salida_ready  = 4'b0000;

        // Reset then idle
        tick();
        tick();
        chk("rst_valid", 32'(salida_valid), 32'h0);
        chk("rst_A", salidaA, 32'h0);
        chk("rst_B", salidaB, 32'h0);
        chk("rst_C", salidaC, 32'h0);
        chk("rst_D", salidaD, 32'h0);
        chk("rst_ocup", 32'(ocupados), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            chk("idle_ready", 32'(entrada_ready), 32'h1);
        end

        // Route all four channels
        for (int i = 0; i < 4; i++) begin
            sel           = 2'(i);
            entrada       = 32'h11111111 * 32'(i + 1);
            entrada_valid = 1'b1;
            #1;
            chk("route_ready", 32'(entrada_ready), 32'h1);
            tick();
        end
        entrada_valid = 1'b0;
        chk("route_valid", 32'(salida_valid), 32'hF);
        chk("route_A", salidaA, 32'h11111111);
        chk("route_B", salidaB, 32'h22222222);
        chk("route_C", salidaC, 32'h33333333);
        chk("route_D", salidaD, 32'h44444444);
        chk("route_ocup", 32'(ocupados), 32'd4);
        sel           = 2'd2;
        entrada_valid = 1'b1;
        #1;
        chk("full_stall", 32'(entrada_ready), 32'h0);
        tick();
        chk("stall_C_held", salidaC, 32'h33333333);
        entrada_valid = 1'b0;

        // Stall isolation: B stays full, D drains then takes a new word
        salida_ready = 4'b1000;
        tick();
        chk("drainD_valid", 32'(salida_valid), 32'h7);
        chk("drainD_ocup", 32'(ocupados), 32'd3);
        salida_ready  = 4'b0000;
        sel           = 2'd3;
        entrada       = 32'hCAFEBABE;
        entrada_valid = 1'b1;
        #1;
        chk("iso_ready", 32'(entrada_ready), 32'h1);
        tick();
        entrada_valid = 1'b0;
        chk("iso_D", salidaD, 32'hCAFEBABE);
        chk("iso_B", salidaB, 32'h22222222);
        chk("iso_valid", 32'(salida_valid), 32'hF);

        // Drain+refill on channel A, twice
        salida_ready  = 4'b0001;
        sel           = 2'd0;
        entrada       = 32'hDEADBEEF;
        entrada_valid = 1'b1;
        #1;
        chk("refill1_ready", 32'(entrada_ready), 32'h1);
        tick();
        chk("refill1_A", salidaA, 32'hDEADBEEF);
        entrada = 32'h12345678;
        #1;
        chk("refill2_ready", 32'(entrada_ready), 32'h1);
        tick();
        entrada_valid = 1'b0;
        salida_ready  = 4'b0000;
        chk("refill2_A", salidaA, 32'h12345678);
        chk("refill2_valid", 32'(salida_valid), 32'hF);
        chk("refill2_ocup", 32'(ocupados), 32'd4);

        // Reset mid-operation with a word on offer
        salida_ready = 4'b1000;
        tick();
        chk("pre_rst_ocup", 32'(ocupados), 32'd3);
        salida_ready  = 4'b0000;
        reset_n       = 1'b0;
        sel           = 2'd3;
        entrada       = 32'hBADF00D5;
        entrada_valid = 1'b1;
        tick();
        chk("midrst_valid", 32'(salida_valid), 32'h0);
        chk("midrst_ocup", 32'(ocupados), 32'd0);
        chk("midrst_D", salidaD, 32'h0);
        reset_n       = 1'b1;
        entrada_valid = 1'b0;
        tick();
        chk("postrst_valid", 32'(salida_valid), 32'h0);
        chk("postrst_ocup", 32'(ocupados), 32'd0);

        // Random traffic against a per-channel scoreboard
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                entrada_valid = 1'($urandom_range(0, 1));
                sel           = 2'($urandom_range(0, 3));
                entrada       = $urandom;
            end
            salida_ready = 4'($urandom);
            #1;
            expRdy = (cola[sel].size() == 0) || salida_ready[sel];
            chk("rnd_ready", 32'(entrada_ready), 32'(expRdy));
            for (int i = 0; i < 4; i++) begin
                if (salida_valid[i] && salida_ready[i]) begin
                    if (cola[i].size() == 0) begin
                        chk("rnd_spurious", 32'(salida_valid[i]), 32'h0);
                    end else begin
                        w = cola[i].pop_front();
                        chk("rnd_data", salidaDe(i), w);
                    end
                end
            end
            acc = entrada_valid && expRdy;
            if (acc) cola[sel].push_back(entrada);
            hold = entrada_valid && !acc;
            tick();
            for (int i = 0; i < 4; i++) expV[i] = (cola[i].size() != 0);
            chk("rnd_valid", 32'(salida_valid), 32'(expV));
            chk("rnd_ocup", 32'(ocupados), 32'(popcnt(salida_valid)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
